ps2_scan_decoder: RTL

PS/2 keyboard receiver and scan-code decoder feeding the drawing-grid cursor FSM. It synchronises and de-glitches the raw PS2_CLK/PS2_DAT pins and deframes 11-bit device-to-host frames. It strips E0 (extended) and F0 (break) prefixes and emits a single-cycle `done_tick` only for completed make codes, so a key release never produces a second cursor move.

---
 rtl/ps2_scan_decoder_if.sv | 11 +
 rtl/ps2_scan_decoder.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/ps2_scan_decoder_if.sv
// Decoded keyboard event bus: the decoder drives it, the cursor FSM consumes it.
interface ps2_scan_decoder_if;
  logic [7:0] scan_code;
  logic       extended;
  logic       done_tick;
  logic       break_tick;
  logic       frame_err;

  modport master (output scan_code, extended, done_tick, break_tick, frame_err);
  modport slave  (input  scan_code, extended, done_tick, break_tick, frame_err);
endinterface

// File: rtl/ps2_scan_decoder.sv
// PS/2 device-to-host receiver: pin conditioning, 11-bit deframing, and E0/F0
// prefix stripping so that only completed make codes raise done_tick.
module ps2_scan_decoder #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic               CLOCK_50,
  input  logic               resetn,
  input  logic               ps2c,
  input  logic               ps2d,
  ps2_scan_decoder_if.master kb
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  logic                  ps2c_p0, ps2c_p1, ps2d_p0, ps2d_p1;
  logic [FILTER_LEN-1:0] filt_sr;
  logic                  filt_lvl;
  logic                  fall;
  logic [1:0]            state;
  logic [2:0]            bit_cnt;
  logic [7:0]            shift;
  logic                  par_bit;
  logic [TW-1:0]         tmo_cnt;
  logic                  tmo_hit;
  logic                  byte_ok_p2, frame_err_p2;
  logic                  ext_pend, brk_pend;
  logic [7:0]            scan_code_p3;
  logic                  extended_p3, done_p3, break_p3;

  function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

  // Stage 0/1: two-flop synchronisers and the ps2c level filter
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      ps2c_p0  <= 1'b1;
      ps2c_p1  <= 1'b1;
      ps2d_p0  <= 1'b1;
      ps2d_p1  <= 1'b1;
      filt_sr  <= '1;
      filt_lvl <= 1'b1;
    end else begin
      ps2c_p0 <= ps2c;
      ps2c_p1 <= ps2c_p0;
      ps2d_p0 <= ps2d;
      ps2d_p1 <= ps2d_p0;
      filt_sr <= {filt_sr[FILTER_LEN-2:0], ps2c_p1};
      if (filt_sr == '0)
        filt_lvl <= 1'b0;
      else if (&filt_sr)
        filt_lvl <= 1'b1;
    end
  end

  // The filtered level drops the cycle after this, so the strobe lasts one cycle.
  assign fall    = filt_lvl && (filt_sr == '0);
  assign tmo_hit = (state != ST_IDLE) && (tmo_cnt == TW'(TIMEOUT_CYCLES));

  // Stage 2: frame FSM and inter-edge timeout
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state        <= ST_IDLE;
      bit_cnt      <= 3'd0;
      shift        <= 8'd0;
      par_bit      <= 1'b0;
      tmo_cnt      <= '0;
      byte_ok_p2   <= 1'b0;
      frame_err_p2 <= 1'b0;
    end else begin
      byte_ok_p2   <= 1'b0;
      frame_err_p2 <= 1'b0;
      if (state == ST_IDLE || fall)
        tmo_cnt <= '0;
      else if (!tmo_hit)
        tmo_cnt <= tmo_cnt + TW'(1);

      if (tmo_hit) begin
        state        <= ST_IDLE;
        frame_err_p2 <= 1'b1;
      end else if (fall) begin
        case (state)
          ST_IDLE: begin
            if (!ps2d_p1) begin
              state   <= ST_DATA;
              bit_cnt <= 3'd0;
            end
          end
          ST_DATA: begin
            shift   <= {ps2d_p1, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7)
              state <= ST_PARITY;
          end
          ST_PARITY: begin
            par_bit <= ps2d_p1;
            state   <= ST_STOP;
          end
          default: begin
            state <= ST_IDLE;
            if (ps2d_p1 && odd_parity_ok(shift, par_bit))
              byte_ok_p2 <= 1'b1;
            else
              frame_err_p2 <= 1'b1;
          end
        endcase
      end
    end
  end

  // Stage 3: prefix layer; shift stays stable here because a new frame needs
  // at least two more falls before it touches the data register.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      ext_pend     <= 1'b0;
      brk_pend     <= 1'b0;
      scan_code_p3 <= 8'd0;
      extended_p3  <= 1'b0;
      done_p3      <= 1'b0;
      break_p3     <= 1'b0;
    end else begin
      done_p3  <= 1'b0;
      break_p3 <= 1'b0;
      if (frame_err_p2) begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
      end else if (byte_ok_p2) begin
        if (shift == 8'hE0) begin
          ext_pend <= 1'b1;
        end else if (shift == 8'hF0) begin
          brk_pend <= 1'b1;
        end else begin
          scan_code_p3 <= shift;
          extended_p3  <= ext_pend;
          if (brk_pend)
            break_p3 <= 1'b1;
          else
            done_p3 <= 1'b1;
          ext_pend <= 1'b0;
          brk_pend <= 1'b0;
        end
      end
    end
  end

  assign kb.scan_code  = scan_code_p3;
  assign kb.extended   = extended_p3;
  assign kb.done_tick  = done_p3;
  assign kb.break_tick = break_p3;
  assign kb.frame_err  = frame_err_p2;
endmodule
